// File: rtl/keyled_ram_arbiter.sv
// keyled_ram_arbiter: two-requester round-robin arbiter in front of a single
// synchronous RAM port with one cycle of read latency.
// Optional ownership lock compiled in with `define KEYLED_ARB_LOCK_EN.
//
// Lock FSM (KEYLED_ARB_LOCK_EN only):
//   state | meaning
//   IDLE  | plain round-robin between m0 and m1
//   OWN0  | m0 holds the RAM, only m0 may be granted
//   OWN1  | m1 holds the RAM, only m1 may be granted
module keyled_ram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  logic       pend0;
  logic       pend1;
  logic       rr_gnt0;
  logic       rr_gnt1;
  logic       gnt0;
  logic       gnt1;
  logic       last_grant;
  logic [1:0] rd_vld;

  assign pend0 = m0_read | m0_write;
  assign pend1 = m1_read | m1_write;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    rr_gnt0 = 1'b0;
    rr_gnt1 = 1'b0;
    if (pend0 && pend1) begin
      rr_gnt0 = last_grant;
      rr_gnt1 = !last_grant;
    end else begin
      rr_gnt0 = pend0;
      rr_gnt1 = pend1;
    end
  end

`ifdef KEYLED_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} lock_state_t;
  lock_state_t lock_state;

  // Final grant: an owner excludes the other requester; nothing is granted in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      case (lock_state)
        OWN0:    gnt0 = pend0;
        OWN1:    gnt1 = pend1;
        default: begin
          gnt0 = rr_gnt0;
          gnt1 = rr_gnt1;
        end
      endcase
    end
  end

  // Lock FSM: enter ownership on a locked grant, leave once the owner drops lock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_state <= IDLE;
    end else begin
      case (lock_state)
        IDLE: begin
          if (gnt0 && m0_lock)      lock_state <= OWN0;
          else if (gnt1 && m1_lock) lock_state <= OWN1;
        end
        OWN0:    if (!m0_lock) lock_state <= IDLE;
        OWN1:    if (!m1_lock) lock_state <= IDLE;
        default: lock_state <= IDLE;
      endcase
    end
  end
`else
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;

  // Final grant: pure round-robin, nothing is granted in reset.
  always_comb begin
    gnt0 = reset_n & rr_gnt0;
    gnt1 = reset_n & rr_gnt1;
  end
`endif

  // Remember who was served last so the next contested cycle goes the other way.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end
  end

  // One-stage read-valid pipeline that steers the RAM response to its requester.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld <= 2'b00;
    end else begin
      rd_vld <= {gnt1 & m1_read, gnt0 & m0_read};
    end
  end

  assign ram_address    = gnt1 ? m1_address    : m0_address;
  assign ram_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign ram_chipselect = gnt0 | gnt1;
  assign ram_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
  assign ram_clken      = 1'b1;

  // Waitrequest is forced high in reset so nobody believes a request was taken.
  assign m0_waitrequest = !reset_n | (pend0 & !gnt0);
  assign m1_waitrequest = !reset_n | (pend1 & !gnt1);

  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rd_vld[0];
  assign m1_readdatavalid = rd_vld[1];

endmodule

// File: tb/tb_keyled_ram_arbiter.sv
// Testbench for keyled_ram_arbiter. Directed stimulus pushes expected read
// responses into a scoreboard queue; a monitor pops them on readdatavalid.
// The lock scenario follows KEYLED_ARB_LOCK_EN so the bench matches the build.
module tb_keyled_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m0_lock = 1'b0;
  logic        m1_read = 1'b0, m1_write = 1'b0, m1_lock = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [13:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_readdata;

  logic [31:0] mem [0:127];
  logic [32:0] sb_q [$];
  int          n_checks = 0;
  int          n_fail = 0;

  keyled_ram_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .reset_n(rst_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_lock(m0_lock), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_lock(m1_lock), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  // RAM model: contents re-initialised in reset, byte-lane writes, 1-cycle reads.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h1000_0000 | i;
      mem[16] <= 32'hDEAD_BEEF;
    end else if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address[6:0]][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address[6:0]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every readdatavalid must match the oldest expected response.
  always @(negedge clk) begin
    logic [32:0] e;
    if (m0_readdatavalid === 1'b1) begin
      if (sb_q.size() == 0) chk("unexpected_rdv0", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("rdv0_owner", 32'(0), 32'(e[32]));
        chk("rdv0_data", m0_readdata, e[31:0]);
        chk("rd0_eq_ram", m0_readdata, ram_readdata);
      end
    end
    if (m1_readdatavalid === 1'b1) begin
      if (sb_q.size() == 0) chk("unexpected_rdv1", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("rdv1_owner", 32'(1), 32'(e[32]));
        chk("rdv1_data", m1_readdata, e[31:0]);
        chk("rd1_eq_ram", m1_readdata, ram_readdata);
      end
    end
  end

  // One cycle: inputs already applied; check combinational outputs, queue reads.
  task automatic step(input string name, input logic e_cs, input logic e_wr,
                      input logic [13:0] e_addr, input logic [3:0] e_be,
                      input logic [31:0] e_wd, input logic e_w0, input logic e_w1,
                      input int e_rd, input logic [31:0] e_data);
    @(negedge clk);
    chk({name, "_cs"}, 32'(ram_chipselect), 32'(e_cs));
    chk({name, "_wr"}, 32'(ram_write), 32'(e_wr));
    chk({name, "_w0"}, 32'(m0_waitrequest), 32'(e_w0));
    chk({name, "_w1"}, 32'(m1_waitrequest), 32'(e_w1));
    if (e_cs) begin
      chk({name, "_addr"}, 32'(ram_address), 32'(e_addr));
      chk({name, "_be"}, 32'(ram_byteenable), 32'(e_be));
    end
    if (e_wr) chk({name, "_wd"}, ram_writedata, e_wd);
    if (e_rd >= 0) sb_q.push_back({e_rd[0], e_data});
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m0_lock = 0; m0_byteenable = 4'hF;
    m1_read = 0; m1_write = 0; m1_lock = 0; m1_byteenable = 4'hF;
  endtask

  task automatic idle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, -1, 0);
  endtask

  // Reset with live requests; all strobes must be quiet and both requesters stalled.
  task automatic reset_phase();
    rst_n = 0;
    m0_write = 1; m0_read = 0; m1_read = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_cs", 32'(ram_chipselect), 32'd0);
      chk("rst_wr", 32'(ram_write), 32'd0);
      chk("rst_w0", 32'(m0_waitrequest), 32'd1);
      chk("rst_w1", 32'(m1_waitrequest), 32'd1);
      chk("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
      chk("rst_rdv1", 32'(m1_readdatavalid), 32'd0);
      chk("clken", 32'(ram_clken), 32'd1);
    end
    @(posedge clk); #1;
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_phase();

    // Single read by m0
    m0_read = 1; m0_address = 14'h0010;
    step("solo_rd0", 1, 0, 14'h0010, 4'hF, 0, 0, 0, 0, 32'hDEAD_BEEF);
    idle(2);

    // Both reading from reset: 0,1,0,1 with no bubbles
    reset_phase();
    m0_read = 1; m0_address = 14'h0020;
    m1_read = 1; m1_address = 14'h0030;
    step("rr_a", 1, 0, 14'h0020, 4'hF, 0, 0, 1, 0, 32'h1000_0020);
    step("rr_b", 1, 0, 14'h0030, 4'hF, 0, 1, 0, 1, 32'h1000_0030);
    step("rr_c", 1, 0, 14'h0020, 4'hF, 0, 0, 1, 0, 32'h1000_0020);
    step("rr_d", 1, 0, 14'h0030, 4'hF, 0, 1, 0, 1, 32'h1000_0030);
    idle(2);

    // m0 partial write contends with m1 read; last winner was m1
    m0_write = 1; m0_address = 14'h0005; m0_byteenable = 4'h3; m0_writedata = 32'h1234_5678;
    m1_read = 1; m1_address = 14'h0040;
    step("wr_win", 1, 1, 14'h0005, 4'h3, 32'h1234_5678, 0, 1, -1, 0);
    m0_write = 0; m0_byteenable = 4'hF;
    step("wr_m1", 1, 0, 14'h0040, 4'hF, 0, 0, 0, 1, 32'h1000_0040);
    m1_read = 0;
    m0_read = 1; m0_address = 14'h0005;
    step("wr_rb", 1, 0, 14'h0005, 4'hF, 0, 0, 0, 0, 32'h1000_5678);
    idle(2);

    // Lock scenario
    reset_phase();
    m1_read = 1; m1_lock = 1; m1_address = 14'h0031;
    step("lk_a", 1, 0, 14'h0031, 4'hF, 0, 0, 0, 1, 32'h1000_0031);
    m0_read = 1; m0_address = 14'h0021;
`ifdef KEYLED_ARB_LOCK_EN
    step("lk_b", 1, 0, 14'h0031, 4'hF, 0, 1, 0, 1, 32'h1000_0031);
    step("lk_c", 1, 0, 14'h0031, 4'hF, 0, 1, 0, 1, 32'h1000_0031);
    m1_read = 0; m1_lock = 0;
    step("lk_d", 0, 0, 0, 0, 0, 1, 0, -1, 0);
    step("lk_e", 1, 0, 14'h0021, 4'hF, 0, 0, 0, 0, 32'h1000_0021);
`else
    step("nolk_b", 1, 0, 14'h0021, 4'hF, 0, 0, 1, 0, 32'h1000_0021);
    step("nolk_c", 1, 0, 14'h0031, 4'hF, 0, 1, 0, 1, 32'h1000_0031);
    step("nolk_d", 1, 0, 14'h0021, 4'hF, 0, 0, 1, 0, 32'h1000_0021);
`endif
    idle(2);

    // Read granted right before reset: its response must be dropped
    m0_read = 1; m0_address = 14'h0010;
    step("pre_rst", 1, 0, 14'h0010, 4'hF, 0, 0, 0, -1, 0);
    reset_phase();
    idle(3);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
